axi_slave_default: RTL and testbench

// - Terminating AXI4 slave for AXI_INF buses: the slave-side counterpart of the master tie-off.
// - Sits on any bus slave port with no real peripheral yet; fully completes every burst so upstream masters and the interconnect never hang.
// - Write data is drained and discarded. Reads return a fixed fill word. Every transaction gets a parameterised response code.
// - Per-channel transaction counters and a protocol-error flag support bring-up.

---
 rtl/axi_default_pkg.sv | 35 +++
 rtl/axi_slave_default_if.sv | 73 +++++++
 rtl/axi_default_rd_gen.sv | 99 +++++++++
 rtl/axi_slave_default.sv | 145 ++++++++++++++
 tb/tb_axi_slave_default.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_default_pkg.sv
// -----------------------------------------------------------------------------
// axi_default_pkg
// Shared definitions for the terminating AXI4 slave:
//   - AXI response code constants
//   - write / read channel FSM state encodings
//   - burst length / beat counter widths and a saturating beat increment
// -----------------------------------------------------------------------------
package axi_default_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int LEN_WIDTH  = 8;
    localparam int BEAT_WIDTH = 9;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Beat counter sticks at all-ones so an overlong burst can never alias
    // back onto a small LEN value.
    function automatic logic [BEAT_WIDTH-1:0] beat_inc(input logic [BEAT_WIDTH-1:0] beat);
        return (beat == '1) ? beat : beat + 1'b1;
    endfunction

endpackage

// File: rtl/axi_slave_default_if.sv
// -----------------------------------------------------------------------------
// AXI_INF
// AXI4 bus bundle shared by masters, the interconnect and slaves.
//   Parameters : ID_WIDTH, ADDR_WIDTH, DATA_WIDTH (LEN is fixed at 8 bits)
//   Channels   : WR_ADDR (AW), WR_DATA (W), WR_BACK (B), RD_ADDR (AR), RD_DATA (R)
//   Modports   : M (master side), S (slave side)
// -----------------------------------------------------------------------------
interface AXI_INF #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import axi_default_pkg::*;

    logic [ID_WIDTH-1:0]     WR_ADDR_ID;
    logic [ADDR_WIDTH-1:0]   WR_ADDR_ADDR;
    logic [LEN_WIDTH-1:0]    WR_ADDR_LEN;
    logic [1:0]              WR_ADDR_BURST;
    logic                    WR_ADDR_VALID;
    logic                    WR_ADDR_READY;

    logic [DATA_WIDTH-1:0]   WR_DATA_DATA;
    logic [DATA_WIDTH/8-1:0] WR_DATA_STRB;
    logic                    WR_DATA_LAST;
    logic                    WR_DATA_VALID;
    logic                    WR_DATA_READY;

    logic [ID_WIDTH-1:0]     WR_BACK_ID;
    logic [1:0]              WR_BACK_RESP;
    logic                    WR_BACK_VALID;
    logic                    WR_BACK_READY;

    logic [ID_WIDTH-1:0]     RD_ADDR_ID;
    logic [ADDR_WIDTH-1:0]   RD_ADDR_ADDR;
    logic [LEN_WIDTH-1:0]    RD_ADDR_LEN;
    logic [1:0]              RD_ADDR_BURST;
    logic                    RD_ADDR_VALID;
    logic                    RD_ADDR_READY;

    logic [ID_WIDTH-1:0]     RD_DATA_ID;
    logic [DATA_WIDTH-1:0]   RD_DATA_DATA;
    logic [1:0]              RD_DATA_RESP;
    logic                    RD_DATA_LAST;
    logic                    RD_DATA_VALID;
    logic                    RD_DATA_READY;

    modport M (
        output WR_ADDR_ID, WR_ADDR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
        input  WR_ADDR_READY,
        output WR_DATA_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
        input  WR_DATA_READY,
        input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
        output WR_BACK_READY,
        output RD_ADDR_ID, RD_ADDR_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
        input  RD_ADDR_READY,
        input  RD_DATA_ID, RD_DATA_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
        output RD_DATA_READY
    );

    modport S (
        input  WR_ADDR_ID, WR_ADDR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
        output WR_ADDR_READY,
        input  WR_DATA_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
        output WR_DATA_READY,
        output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
        input  WR_BACK_READY,
        input  RD_ADDR_ID, RD_ADDR_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
        output RD_ADDR_READY,
        output RD_DATA_ID, RD_DATA_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
        input  RD_DATA_READY
    );

endinterface

// File: rtl/axi_default_rd_gen.sv
// -----------------------------------------------------------------------------
// axi_default_rd_gen
// Read channel of the terminating slave: accepts one AR burst at a time and
// returns LEN+1 beats of a constant fill word with a fixed response code.
//   clk, rstn      : clock, asynchronous active-low reset
//   ar_valid/ready : AR handshake, ar_id / ar_len latched on accept
//   r_*            : R channel outputs, all registered
//   rd_txn_cnt     : bursts completed (last R handshake), wraps
// -----------------------------------------------------------------------------
module axi_default_rd_gen
    import axi_default_pkg::*;
#(
    parameter int         ID_W      = 4,
    parameter int         DATA_W    = 32,
    parameter logic [1:0] RESP_CODE = RESP_DECERR,
    parameter logic [31:0] RD_FILL  = 32'hDEAD_BEEF,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ar_valid,
    input  logic [ID_W-1:0]      ar_id,
    input  logic [LEN_WIDTH-1:0] ar_len,
    output logic                 ar_ready,
    input  logic                 r_ready,
    output logic                 r_valid,
    output logic [ID_W-1:0]      r_id,
    output logic [DATA_W-1:0]    r_data,
    output logic [1:0]           r_resp,
    output logic                 r_last,
    output logic [CNT_WIDTH-1:0] rd_txn_cnt
);

    localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(RD_FILL);

    rd_state_t            rd_state_reg, rd_state_next;
    logic [ID_W-1:0]      rd_id_reg, rd_id_next;
    logic [LEN_WIDTH-1:0] remaining_reg, remaining_next;
    logic [CNT_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;

    always_comb begin
        rd_state_next  = rd_state_reg;
        rd_id_next     = rd_id_reg;
        remaining_next = remaining_reg;
        rd_cnt_next    = rd_cnt_reg;
        case (rd_state_reg)
            R_IDLE: begin
                // ar_ready is low for the first cycle after reset, so gate on it.
                if (ar_valid && ar_ready) begin
                    rd_id_next     = ar_id;
                    remaining_next = ar_len;
                    rd_state_next  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready && r_valid) begin
                    if (remaining_reg == '0) begin
                        rd_cnt_next   = rd_cnt_reg + 1'b1;
                        rd_state_next = R_IDLE;
                    end else begin
                        remaining_next = remaining_reg - 1'b1;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state implies, so no
    // input ever reaches READY/VALID combinationally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_reg  <= R_IDLE;
            rd_id_reg     <= '0;
            remaining_reg <= '0;
            rd_cnt_reg    <= '0;
            ar_ready      <= 1'b0;
            r_valid       <= 1'b0;
            r_id          <= '0;
            r_data        <= '0;
            r_resp        <= '0;
            r_last        <= 1'b0;
        end else begin
            rd_state_reg  <= rd_state_next;
            rd_id_reg     <= rd_id_next;
            remaining_reg <= remaining_next;
            rd_cnt_reg    <= rd_cnt_next;
            ar_ready      <= (rd_state_next == R_IDLE);
            r_valid       <= (rd_state_next == R_DATA);
            r_id          <= rd_id_next;
            r_data        <= (rd_state_next == R_DATA) ? FILL_WORD : '0;
            r_resp        <= (rd_state_next == R_DATA) ? RESP_CODE : 2'b00;
            r_last        <= (rd_state_next == R_DATA) && (remaining_next == '0);
        end
    end

    assign rd_txn_cnt = rd_cnt_reg;

endmodule

// File: rtl/axi_slave_default.sv
// -----------------------------------------------------------------------------
// axi_slave_default
// Terminating AXI4 slave: completes every burst so masters never hang.
// Write data is drained and dropped, reads return a fill word, every
// transaction answers with RESP_CODE.
//   clk, rstn   : clock, asynchronous active-low reset
//   AXI_S       : AXI_INF slave modport
//   wr_txn_cnt  : write bursts completed (B handshake), wraps
//   rd_txn_cnt  : read bursts completed (last R handshake), wraps
//   proto_err   : sticky, WR_DATA_LAST disagreed with the AW length
// -----------------------------------------------------------------------------
module axi_slave_default
    import axi_default_pkg::*;
#(
    parameter logic [1:0]  RESP_CODE = RESP_DECERR,
    parameter logic [31:0] RD_FILL   = 32'hDEAD_BEEF,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    AXI_INF.S                    AXI_S,
    output logic [CNT_WIDTH-1:0] wr_txn_cnt,
    output logic [CNT_WIDTH-1:0] rd_txn_cnt,
    output logic                 proto_err
);

    localparam int ID_W   = $bits(AXI_S.WR_BACK_ID);
    localparam int DATA_W = $bits(AXI_S.RD_DATA_DATA);

    wr_state_t             wr_state_reg, wr_state_next;
    logic [ID_W-1:0]       wr_id_reg, wr_id_next;
    logic [LEN_WIDTH-1:0]  wr_len_reg, wr_len_next;
    logic [BEAT_WIDTH-1:0] wr_beat_reg, wr_beat_next;
    logic                  proto_err_reg, proto_err_next;
    logic [CNT_WIDTH-1:0]  wr_cnt_reg, wr_cnt_next;
    logic                  aw_ready_reg, w_ready_reg, b_valid_reg;
    logic [1:0]            b_resp_reg;

    logic beat_is_len;
    assign beat_is_len = (wr_beat_reg == {1'b0, wr_len_reg});

    always_comb begin
        wr_state_next  = wr_state_reg;
        wr_id_next     = wr_id_reg;
        wr_len_next    = wr_len_reg;
        wr_beat_next   = wr_beat_reg;
        proto_err_next = proto_err_reg;
        wr_cnt_next    = wr_cnt_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (AXI_S.WR_ADDR_VALID && aw_ready_reg) begin
                    wr_id_next    = AXI_S.WR_ADDR_ID;
                    wr_len_next   = AXI_S.WR_ADDR_LEN;
                    wr_beat_next  = '0;
                    wr_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (AXI_S.WR_DATA_VALID && w_ready_reg) begin
                    wr_beat_next = beat_inc(wr_beat_reg);
                    // LAST decides the exit; a length mismatch in either
                    // direction only raises the flag.
                    if (AXI_S.WR_DATA_LAST) begin
                        if (!beat_is_len) begin
                            proto_err_next = 1'b1;
                        end
                        wr_state_next = W_RESP;
                    end else if (beat_is_len) begin
                        proto_err_next = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (AXI_S.WR_BACK_READY && b_valid_reg) begin
                    wr_cnt_next   = wr_cnt_reg + 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_reg  <= W_IDLE;
            wr_id_reg     <= '0;
            wr_len_reg    <= '0;
            wr_beat_reg   <= '0;
            proto_err_reg <= 1'b0;
            wr_cnt_reg    <= '0;
            aw_ready_reg  <= 1'b0;
            w_ready_reg   <= 1'b0;
            b_valid_reg   <= 1'b0;
            b_resp_reg    <= 2'b00;
        end else begin
            wr_state_reg  <= wr_state_next;
            wr_id_reg     <= wr_id_next;
            wr_len_reg    <= wr_len_next;
            wr_beat_reg   <= wr_beat_next;
            proto_err_reg <= proto_err_next;
            wr_cnt_reg    <= wr_cnt_next;
            aw_ready_reg  <= (wr_state_next == W_IDLE);
            w_ready_reg   <= (wr_state_next == W_DATA);
            b_valid_reg   <= (wr_state_next == W_RESP);
            b_resp_reg    <= (wr_state_next == W_RESP) ? RESP_CODE : 2'b00;
        end
    end

    assign AXI_S.WR_ADDR_READY = aw_ready_reg;
    assign AXI_S.WR_DATA_READY = w_ready_reg;
    assign AXI_S.WR_BACK_VALID = b_valid_reg;
    assign AXI_S.WR_BACK_ID    = wr_id_reg;
    assign AXI_S.WR_BACK_RESP  = b_resp_reg;
    assign wr_txn_cnt          = wr_cnt_reg;
    assign proto_err           = proto_err_reg;

    axi_default_rd_gen #(
        .ID_W      (ID_W),
        .DATA_W    (DATA_W),
        .RESP_CODE (RESP_CODE),
        .RD_FILL   (RD_FILL),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rd_gen (
        .clk        (clk),
        .rstn       (rstn),
        .ar_valid   (AXI_S.RD_ADDR_VALID),
        .ar_id      (AXI_S.RD_ADDR_ID),
        .ar_len     (AXI_S.RD_ADDR_LEN),
        .ar_ready   (AXI_S.RD_ADDR_READY),
        .r_ready    (AXI_S.RD_DATA_READY),
        .r_valid    (AXI_S.RD_DATA_VALID),
        .r_id       (AXI_S.RD_DATA_ID),
        .r_data     (AXI_S.RD_DATA_DATA),
        .r_resp     (AXI_S.RD_DATA_RESP),
        .r_last     (AXI_S.RD_DATA_LAST),
        .rd_txn_cnt (rd_txn_cnt)
    );

    // Address, burst type and write payload are accepted and dropped.
    logic unused_bus;
    assign unused_bus = ^{AXI_S.WR_ADDR_ADDR, AXI_S.WR_ADDR_BURST,
                          AXI_S.WR_DATA_DATA, AXI_S.WR_DATA_STRB,
                          AXI_S.RD_ADDR_ADDR, AXI_S.RD_ADDR_BURST};

endmodule

// File: tb/tb_axi_slave_default.sv
module tb_axi_slave_default;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] wr_txn_cnt;
    logic [15:0] rd_txn_cnt;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;
    int exp_wr_cnt = 0;
    int exp_rd_cnt = 0;

    localparam logic [31:0] FILL = 32'hDEADBEEF;
    localparam logic [1:0]  RESP = 2'b11;

    always #5 clk = ~clk;

    AXI_INF #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_slave_default dut (
        .clk        (clk),
        .rstn       (rstn),
        .AXI_S      (bus.S),
        .wr_txn_cnt (wr_txn_cnt),
        .rd_txn_cnt (rd_txn_cnt),
        .proto_err  (proto_err)
    );

    typedef struct {
        logic [3:0] id;
        logic [7:0] len;
        int         nbeats;
        int         bdelay;
        logic       exp_perr;
    } wr_vec_t;

    typedef struct {
        logic [3:0] id;
        logic [7:0] len;
        logic       toggle;
    } rd_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [3:0] id, input logic [7:0] len,
                            input int nbeats, input int bdelay, input logic exp_perr);
        int guard;
        bus.WR_ADDR_ID    = id;
        bus.WR_ADDR_LEN   = len;
        bus.WR_ADDR_ADDR  = $urandom;
        bus.WR_ADDR_VALID = 1'b1;
        guard = 0;
        while (!bus.WR_ADDR_READY && guard < 20) begin tick(); guard++; end
        check({tag, "_awready"}, bus.WR_ADDR_READY, 1);
        tick();
        bus.WR_ADDR_VALID = 1'b0;
        check({tag, "_wready_lat"}, bus.WR_DATA_READY, 1);
        check({tag, "_awready_busy"}, bus.WR_ADDR_READY, 0);
        for (int b = 0; b < nbeats; b++) begin
            bus.WR_DATA_VALID = 1'b1;
            bus.WR_DATA_LAST  = (b == nbeats - 1);
            bus.WR_DATA_DATA  = $urandom;
            guard = 0;
            while (!bus.WR_DATA_READY && guard < 20) begin tick(); guard++; end
            if (guard >= 20) check({tag, "_wready_to"}, 0, 1);
            tick();
        end
        bus.WR_DATA_VALID = 1'b0;
        bus.WR_DATA_LAST  = 1'b0;
        check({tag, "_bvalid_lat"}, bus.WR_BACK_VALID, 1);
        check({tag, "_wready_off"}, bus.WR_DATA_READY, 0);
        check({tag, "_bid"}, bus.WR_BACK_ID, id);
        check({tag, "_bresp"}, bus.WR_BACK_RESP, RESP);
        for (int d = 0; d < bdelay; d++) begin
            tick();
            check({tag, "_bvalid_hold"}, bus.WR_BACK_VALID, 1);
            check({tag, "_bid_hold"}, bus.WR_BACK_ID, id);
        end
        bus.WR_BACK_READY = 1'b1;
        tick();
        bus.WR_BACK_READY = 1'b0;
        exp_wr_cnt++;
        check({tag, "_bvalid_off"}, bus.WR_BACK_VALID, 0);
        check({tag, "_wr_cnt"}, wr_txn_cnt, exp_wr_cnt[15:0]);
        check({tag, "_proto_err"}, proto_err, exp_perr);
        check({tag, "_awready_back"}, bus.WR_ADDR_READY, 1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] id, input logic [7:0] len,
                           input logic toggle);
        int   guard;
        int   beats;
        int   cyc;
        logic done;
        bus.RD_ADDR_ID    = id;
        bus.RD_ADDR_LEN   = len;
        bus.RD_ADDR_ADDR  = $urandom;
        bus.RD_ADDR_VALID = 1'b1;
        guard = 0;
        while (!bus.RD_ADDR_READY && guard < 20) begin tick(); guard++; end
        check({tag, "_arready"}, bus.RD_ADDR_READY, 1);
        tick();
        bus.RD_ADDR_VALID = 1'b0;
        check({tag, "_rvalid_lat"}, bus.RD_DATA_VALID, 1);
        beats = 0;
        cyc   = 0;
        done  = 1'b0;
        while (!done && cyc < 64) begin
            bus.RD_DATA_READY = toggle ? ~cyc[0] : 1'b1;
            check({tag, "_rvalid"}, bus.RD_DATA_VALID, 1);
            check({tag, "_rdata"}, bus.RD_DATA_DATA, FILL);
            check({tag, "_rid"}, bus.RD_DATA_ID, id);
            check({tag, "_rresp"}, bus.RD_DATA_RESP, RESP);
            check({tag, "_rlast"}, bus.RD_DATA_LAST, (beats == int'(len)));
            if (bus.RD_DATA_READY && bus.RD_DATA_VALID) begin
                beats++;
                if (bus.RD_DATA_LAST) done = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.RD_DATA_READY = 1'b0;
        exp_rd_cnt++;
        check({tag, "_beats"}, beats, int'(len) + 1);
        check({tag, "_rvalid_off"}, bus.RD_DATA_VALID, 0);
        check({tag, "_rd_cnt"}, rd_txn_cnt, exp_rd_cnt[15:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t wr_tab[5];
        rd_vec_t rd_tab[3];

        wr_tab[0] = '{id: 4'd3,  len: 8'd3, nbeats: 4, bdelay: 0, exp_perr: 1'b0};
        wr_tab[1] = '{id: 4'd9,  len: 8'd0, nbeats: 1, bdelay: 2, exp_perr: 1'b0};
        wr_tab[2] = '{id: 4'd15, len: 8'd7, nbeats: 8, bdelay: 1, exp_perr: 1'b0};
        wr_tab[3] = '{id: 4'd1,  len: 8'd3, nbeats: 2, bdelay: 0, exp_perr: 1'b1};
        wr_tab[4] = '{id: 4'd2,  len: 8'd1, nbeats: 2, bdelay: 0, exp_perr: 1'b1};

        rd_tab[0] = '{id: 4'd5,  len: 8'd7, toggle: 1'b1};
        rd_tab[1] = '{id: 4'd2,  len: 8'd0, toggle: 1'b0};
        rd_tab[2] = '{id: 4'd12, len: 8'd3, toggle: 1'b1};

        bus.WR_ADDR_ID = '0; bus.WR_ADDR_ADDR = '0; bus.WR_ADDR_LEN = '0;
        bus.WR_ADDR_BURST = 2'b01; bus.WR_ADDR_VALID = 1'b0;
        bus.WR_DATA_DATA = '0; bus.WR_DATA_STRB = '1; bus.WR_DATA_LAST = 1'b0;
        bus.WR_DATA_VALID = 1'b0; bus.WR_BACK_READY = 1'b0;
        bus.RD_ADDR_ID = '0; bus.RD_ADDR_ADDR = '0; bus.RD_ADDR_LEN = '0;
        bus.RD_ADDR_BURST = 2'b01; bus.RD_ADDR_VALID = 1'b0; bus.RD_DATA_READY = 1'b0;

        // Reset held 5 cycles.
        for (int i = 0; i < 5; i++) tick();
        check("rst_awready", bus.WR_ADDR_READY, 0);
        check("rst_arready", bus.RD_ADDR_READY, 0);
        check("rst_wready", bus.WR_DATA_READY, 0);
        check("rst_bvalid", bus.WR_BACK_VALID, 0);
        check("rst_rvalid", bus.RD_DATA_VALID, 0);
        check("rst_bid_bresp", {bus.WR_BACK_ID, bus.WR_BACK_RESP}, 0);
        check("rst_r_fields", {bus.RD_DATA_ID, bus.RD_DATA_DATA, bus.RD_DATA_RESP, bus.RD_DATA_LAST}, 0);
        check("rst_counters", {wr_txn_cnt, rd_txn_cnt, proto_err}, 0);
        rstn = 1'b1;
        tick();
        check("rel_awready", bus.WR_ADDR_READY, 1);
        check("rel_arready", bus.RD_ADDR_READY, 1);

        foreach (wr_tab[i])
            do_write($sformatf("wr%0d", i), wr_tab[i].id, wr_tab[i].len,
                     wr_tab[i].nbeats, wr_tab[i].bdelay, wr_tab[i].exp_perr);

        foreach (rd_tab[i])
            do_read($sformatf("rd%0d", i), rd_tab[i].id, rd_tab[i].len, rd_tab[i].toggle);

        // Concurrent single-beat write and read, B held off for 10 cycles.
        bus.WR_ADDR_ID = 4'd7;  bus.WR_ADDR_LEN = 8'd0; bus.WR_ADDR_VALID = 1'b1;
        bus.RD_ADDR_ID = 4'd10; bus.RD_ADDR_LEN = 8'd0; bus.RD_ADDR_VALID = 1'b1;
        check("cc_both_ready", {bus.WR_ADDR_READY, bus.RD_ADDR_READY}, 2'b11);
        tick();
        bus.WR_ADDR_VALID = 1'b0;
        bus.RD_ADDR_VALID = 1'b0;
        check("cc_wready", bus.WR_DATA_READY, 1);
        check("cc_r_first", {bus.RD_DATA_VALID, bus.RD_DATA_LAST, bus.RD_DATA_ID}, {2'b11, 4'd10});
        bus.WR_DATA_VALID = 1'b1;
        bus.WR_DATA_LAST  = 1'b1;
        bus.RD_DATA_READY = 1'b1;
        tick();
        bus.WR_DATA_VALID = 1'b0;
        bus.WR_DATA_LAST  = 1'b0;
        bus.RD_DATA_READY = 1'b0;
        exp_rd_cnt++;
        check("cc_rvalid_off", bus.RD_DATA_VALID, 0);
        check("cc_rd_cnt", rd_txn_cnt, exp_rd_cnt[15:0]);
        check("cc_bvalid", bus.WR_BACK_VALID, 1);
        for (int d = 0; d < 10; d++) begin
            tick();
            check("cc_b_hold", {bus.WR_BACK_VALID, bus.WR_BACK_ID, bus.WR_BACK_RESP}, {1'b1, 4'd7, RESP});
        end
        check("cc_wr_cnt_wait", wr_txn_cnt, exp_wr_cnt[15:0]);
        bus.WR_BACK_READY = 1'b1;
        tick();
        bus.WR_BACK_READY = 1'b0;
        exp_wr_cnt++;
        check("cc_wr_cnt", wr_txn_cnt, exp_wr_cnt[15:0]);
        check("cc_bvalid_off", bus.WR_BACK_VALID, 0);

        // Reset in the middle of an 8-beat read.
        bus.RD_ADDR_ID = 4'd8; bus.RD_ADDR_LEN = 8'd7; bus.RD_ADDR_VALID = 1'b1;
        tick();
        bus.RD_ADDR_VALID = 1'b0;
        bus.RD_DATA_READY = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mr_rvalid_pre", bus.RD_DATA_VALID, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("mr_rvalid_async", bus.RD_DATA_VALID, 0);
        check("mr_readys", {bus.WR_ADDR_READY, bus.RD_ADDR_READY}, 0);
        check("mr_counters", {wr_txn_cnt, rd_txn_cnt, proto_err}, 0);
        bus.RD_DATA_READY = 1'b0;
        exp_wr_cnt = 0;
        exp_rd_cnt = 0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("mr_arready", bus.RD_ADDR_READY, 1);
        check("mr_no_resp", bus.RD_DATA_VALID, 0);
        do_read("mr_rd", 4'd4, 8'd1, 1'b0);

        // LAST arrives late: flag raised on the beat matching LEN, bus drained.
        do_write("late", 4'd6, 8'd1, 4, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
